// File: rtl/rotary_bcd_counter.sv
// Two-digit BCD up/down counter driven by rotary-encoder pulses, with a
// UNITS/TENS/LOCK step-mode FSM and a one-cycle wrap/clip indicator.
module rotary_bcd_counter #(
    parameter bit         WRAP     = 1'b1,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       left_pulse,
    input  logic       right_pulse,
    input  logic       d_pulse,
    output logic [7:0] seg_data,
    output logic       seg_data_d,
    output logic [1:0] mode,
    output logic       limit_pulse
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] DIGIT_MIN = DIGIT_W'(0);
    localparam logic [DIGIT_W-1:0] DIGIT_ONE = DIGIT_W'(1);

    typedef enum logic [1:0] {
        UNITS = 2'b00,
        TENS  = 2'b01,
        LOCK  = 2'b10
    } mode_t;

    mode_t              state_q;
    mode_t              state_d;
    logic [DIGIT_W-1:0] tens_q;
    logic [DIGIT_W-1:0] units_q;
    logic [DIGIT_W-1:0] tens_d;
    logic [DIGIT_W-1:0] units_d;
    logic               limit_d;
    logic               seg_dp_q;
    logic               limit_q;
    logic               inc;
    logic               dec;

    // Opposing pulses in the same cycle cancel each other out.
    assign inc = right_pulse & ~left_pulse;
    assign dec = left_pulse & ~right_pulse;

    // Mode sequencing: UNITS -> TENS -> LOCK -> UNITS on each d_pulse.
    always_comb begin
        state_d = state_q;
        if (d_pulse) begin
            case (state_q)
                UNITS:   state_d = TENS;
                TENS:    state_d = LOCK;
                default: state_d = UNITS;
            endcase
        end
    end

    // BCD step using the mode held before this edge.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        limit_d = 1'b0;
        case (state_q)
            UNITS: begin
                if (inc) begin
                    if (units_q == DIGIT_MAX) begin
                        units_d = DIGIT_MIN;
                        if (tens_q == DIGIT_MAX) begin
                            limit_d = 1'b1;
                            if (WRAP) begin
                                tens_d = DIGIT_MIN;
                            end else begin
                                tens_d  = DIGIT_MAX;
                                units_d = DIGIT_MAX;
                            end
                        end else begin
                            tens_d = tens_q + DIGIT_ONE;
                        end
                    end else begin
                        units_d = units_q + DIGIT_ONE;
                    end
                end else if (dec) begin
                    if (units_q == DIGIT_MIN) begin
                        units_d = DIGIT_MAX;
                        if (tens_q == DIGIT_MIN) begin
                            limit_d = 1'b1;
                            if (WRAP) begin
                                tens_d = DIGIT_MAX;
                            end else begin
                                tens_d  = DIGIT_MIN;
                                units_d = DIGIT_MIN;
                            end
                        end else begin
                            tens_d = tens_q - DIGIT_ONE;
                        end
                    end else begin
                        units_d = units_q - DIGIT_ONE;
                    end
                end
            end
            TENS: begin
                if (inc) begin
                    if (tens_q == DIGIT_MAX) begin
                        limit_d = 1'b1;
                        // Saturation clamps the whole value to 99, not just tens.
                        if (WRAP) tens_d = DIGIT_MIN;
                        else      units_d = DIGIT_MAX;
                    end else begin
                        tens_d = tens_q + DIGIT_ONE;
                    end
                end else if (dec) begin
                    if (tens_q == DIGIT_MIN) begin
                        limit_d = 1'b1;
                        if (WRAP) tens_d = DIGIT_MAX;
                        else      units_d = DIGIT_MIN;
                    end else begin
                        tens_d = tens_q - DIGIT_ONE;
                    end
                end
            end
            default: begin
                tens_d  = tens_q;
                units_d = units_q;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= UNITS;
            tens_q   <= INIT_VAL[7:4];
            units_q  <= INIT_VAL[3:0];
            seg_dp_q <= 1'b0;
            limit_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            seg_dp_q <= (state_d == LOCK);
            limit_q  <= limit_d;
        end
    end

    assign seg_data    = {tens_q, units_q};
    assign seg_data_d  = seg_dp_q;
    assign mode        = state_q;
    assign limit_pulse = limit_q;

endmodule

// File: tb/tb_rotary_bcd_counter.sv
// Directed bench for rotary_bcd_counter: one wrapping and one saturating
// instance, both reset to 42, stepped by hand-computed pulse sequences.
module tb_rotary_bcd_counter;

    localparam logic [7:0] INIT = 8'h42;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       l_a, r_a, d_a, l_b, r_b, d_b;
    logic [7:0] seg_a, seg_b;
    logic       dp_a, dp_b, lim_a, lim_b;
    logic [1:0] mode_a, mode_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    rotary_bcd_counter #(.WRAP(1'b1), .INIT_VAL(INIT)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .left_pulse(l_a), .right_pulse(r_a), .d_pulse(d_a),
        .seg_data(seg_a), .seg_data_d(dp_a), .mode(mode_a), .limit_pulse(lim_a)
    );

    rotary_bcd_counter #(.WRAP(1'b0), .INIT_VAL(INIT)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .left_pulse(l_b), .right_pulse(r_b), .d_pulse(d_b),
        .seg_data(seg_b), .seg_data_d(dp_b), .mode(mode_b), .limit_pulse(lim_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_dut(input bit sel, input string tag, input logic [7:0] seg,
                              input logic [1:0] md, input logic lim);
        if (sel) begin
            check({tag, "_seg"}, 32'(seg_b), 32'(seg));
            check({tag, "_mode"}, 32'(mode_b), 32'(md));
            check({tag, "_dp"}, 32'(dp_b), 32'(md == 2'b10));
            check({tag, "_lim"}, 32'(lim_b), 32'(lim));
        end else begin
            check({tag, "_seg"}, 32'(seg_a), 32'(seg));
            check({tag, "_mode"}, 32'(mode_a), 32'(md));
            check({tag, "_dp"}, 32'(dp_a), 32'(md == 2'b10));
            check({tag, "_lim"}, 32'(lim_a), 32'(lim));
        end
    endtask

    // Entered on a falling edge; pulses span one rising edge, returns on the next falling edge.
    task automatic step(input bit sel, input logic l, input logic r, input logic d);
        if (sel) begin l_b = l; r_b = r; d_b = d; end
        else     begin l_a = l; r_a = r; d_a = d; end
        @(negedge clk_in);
        l_a = 1'b0; r_a = 1'b0; d_a = 1'b0;
        l_b = 1'b0; r_b = 1'b0; d_b = 1'b0;
    endtask

    logic [7:0] exp_seq [0:9];

    initial begin
        if (INIT[7:4] > 4'd9 || INIT[3:0] > 4'd9)
            $fatal(1, "FAIL init_val: INIT_VAL %0h is not valid BCD", INIT);

        rst_n_in = 1'b0;
        l_a = 1'b0; r_a = 1'b0; d_a = 1'b0;
        l_b = 1'b0; r_b = 1'b0; d_b = 1'b0;
        repeat (2) @(negedge clk_in);
        expect_dut(0, "rst_a", 8'h42, 2'b00, 1'b0);
        expect_dut(1, "rst_b", 8'h42, 2'b00, 1'b0);
        rst_n_in = 1'b1;

        // Idle after release: value held, no flags.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            expect_dut(0, "idle", 8'h42, 2'b00, 1'b0);
        end

        // WRAP=1: TENS borrow through 00 wraps to 90s.
        step(0, 0, 0, 1);
        expect_dut(0, "to_tens", 8'h42, 2'b01, 1'b0);
        exp_seq[0] = 8'h32; exp_seq[1] = 8'h22; exp_seq[2] = 8'h12; exp_seq[3] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            expect_dut(0, "tens_dn", exp_seq[i], 2'b01, 1'b0);
        end
        step(0, 1, 0, 0);
        expect_dut(0, "tens_wrap_dn", 8'h92, 2'b01, 1'b1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_dut(0, "back_units", 8'h92, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        expect_dut(0, "at_98", 8'h98, 2'b00, 1'b0);

        // WRAP=1 UNITS through the 99/00 boundary both ways.
        step(0, 0, 1, 0); expect_dut(0, "up_99", 8'h99, 2'b00, 1'b0);
        step(0, 0, 1, 0); expect_dut(0, "up_00", 8'h00, 2'b00, 1'b1);
        step(0, 0, 1, 0); expect_dut(0, "up_01", 8'h01, 2'b00, 1'b0);
        step(0, 1, 0, 0); expect_dut(0, "dn_00", 8'h00, 2'b00, 1'b0);
        step(0, 1, 0, 0); expect_dut(0, "dn_99", 8'h99, 2'b00, 1'b1);
        step(0, 1, 0, 0); expect_dut(0, "dn_98", 8'h98, 2'b00, 1'b0);

        // WRAP=0: climb to 95 in TENS, then clip at 99 and 00.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        expect_dut(1, "b_45", 8'h45, 2'b00, 1'b0);
        step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        expect_dut(1, "b_95", 8'h95, 2'b01, 1'b0);
        step(1, 0, 1, 0); expect_dut(1, "sat_hi", 8'h99, 2'b01, 1'b1);
        step(1, 0, 1, 0); expect_dut(1, "sat_hi_hold", 8'h99, 2'b01, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 0);
            expect_dut(1, "sat_dn", 8'(8'h89 - 8'(i * 16)), 2'b01, 1'b0);
        end
        step(1, 1, 0, 0); expect_dut(1, "sat_lo", 8'h00, 2'b01, 1'b1);
        step(1, 1, 0, 0); expect_dut(1, "sat_lo_hold", 8'h00, 2'b01, 1'b1);
        @(negedge clk_in);
        expect_dut(1, "lim_drop", 8'h00, 2'b01, 1'b0);

        // LOCK ignores rotation.
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
        expect_dut(0, "at_10", 8'h10, 2'b00, 1'b0);
        step(0, 0, 0, 1); expect_dut(0, "lk_tens", 8'h10, 2'b01, 1'b0);
        step(0, 0, 0, 1); expect_dut(0, "lk_lock", 8'h10, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            expect_dut(0, "lk_rot", 8'h10, 2'b10, 1'b0);
        end
        step(0, 1, 0, 0); expect_dut(0, "lk_left", 8'h10, 2'b10, 1'b0);
        step(0, 0, 0, 1); expect_dut(0, "lk_exit", 8'h10, 2'b00, 1'b0);

        // Simultaneous events.
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        expect_dut(0, "at_50", 8'h50, 2'b01, 1'b0);
        step(0, 1, 1, 0); expect_dut(0, "lr_both", 8'h50, 2'b01, 1'b0);
        step(0, 1, 0, 0); expect_dut(0, "at_40", 8'h40, 2'b01, 1'b0);
        step(0, 0, 1, 1); expect_dut(0, "d_and_r", 8'h50, 2'b10, 1'b0);

        // Reach 77/TENS, then asynchronous reset between edges.
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_dut(0, "at_77", 8'h77, 2'b01, 1'b0);
        #2;
        r_a = 1'b1;
        rst_n_in = 1'b0;
        #1;
        expect_dut(0, "async_rst_a", 8'h42, 2'b00, 1'b0);
        expect_dut(1, "async_rst_b", 8'h42, 2'b00, 1'b0);
        @(negedge clk_in);
        expect_dut(0, "rst_hold", 8'h42, 2'b00, 1'b0);
        // Pulse coincident with release behaves as one ordinary step.
        rst_n_in = 1'b1;
        step(0, 0, 1, 0);
        expect_dut(0, "rel_pulse", 8'h43, 2'b00, 1'b0);
        @(negedge clk_in);
        expect_dut(0, "rel_settle", 8'h43, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
